// File: rtl/kyber_pkg.sv
// Shared constants and types for the q = 3329 NTT datapath.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package kyber_pkg;
    localparam int Q             = 3329;
    localparam int BARRETT_M     = 5039;
    localparam int BARRETT_SHIFT = 24;
    localparam int COEFF_W       = 12;
    localparam int N             = 8;

    typedef logic [COEFF_W-1:0] coeff_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;
endpackage

// File: rtl/mod_mult_q.sv
// Modular multiplier mod q: registered 24-bit product, then Barrett reduction.
// Latency: product registered one cycle after issue; the reduced value is
//          presented combinationally from that register and captured by the consumer.
// Backpressure: none; one operand pair is accepted every cycle.
module mod_mult_q
    import kyber_pkg::*;
#(
    parameter int IDX_W = 3
) (
    input  logic             clk,
    input  logic             r,
    input  logic             in_vld,
    input  logic [IDX_W-1:0] in_idx,
    input  coeff_t           in_a,
    input  coeff_t           in_b,
    output logic             out_vld,
    output logic [IDX_W-1:0] out_idx,
    output coeff_t           out_res
);
    logic [23:0]      p_d, p_q;
    logic             vld_d, vld_q;
    logic [IDX_W-1:0] idx_d, idx_q;
    logic [36:0]      pm;
    logic [12:0]      t;
    logic [24:0]      tq;
    logic [24:0]      rr;
    logic [24:0]      red;

    // Stage 1: full product plus the lane sideband that travels with it.
    always_comb begin
        p_d   = 24'(in_a) * 24'(in_b);
        vld_d = in_vld;
        idx_d = in_idx;
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            p_q   <= '0;
            vld_q <= 1'b0;
            idx_q <= '0;
        end else begin
            p_q   <= p_d;
            vld_q <= vld_d;
            idx_q <= idx_d;
        end
    end

    // Stage 2: Barrett estimate leaves rr < 2q for any 24-bit p, so one
    // conditional subtract is enough even for operands >= q.
    always_comb begin
        pm      = 37'(p_q) * 37'(BARRETT_M);
        t       = 13'(pm >> BARRETT_SHIFT);
        tq      = 25'(t) * 25'(Q);
        rr      = 25'(p_q) - tq;
        red     = (rr >= 25'(Q)) ? (rr - 25'(Q)) : rr;
        out_res = coeff_t'(red);
        out_vld = vld_q;
        out_idx = idx_q;
    end
endmodule

// File: rtl/pointwise_mul_ntt.sv
// Lane-wise a[i]*b[i] mod 3329 over N lanes through one shared multiplier.
// Latency: 9 cycles from acceptance to valid_out; one vector per 10 cycles.
// Backpressure: busy high while a vector is in flight; valid_in ignored then.
// Optional feature: PWM_RANGE_CHK_EN adds range_err (operand >= q at acceptance).
module pointwise_mul_ntt
    import kyber_pkg::*;
#(
    parameter int N       = kyber_pkg::N,
    parameter int COEFF_W = kyber_pkg::COEFF_W
) (
    input  logic               clk,
    input  logic               r,
    input  logic [COEFF_W-1:0] a_coeffs   [N-1:0],
    input  logic [COEFF_W-1:0] b_coeffs   [N-1:0],
    input  logic               valid_in,
    output logic               busy,
    output logic               valid_out,
    output logic [COEFF_W-1:0] coeffs_out [N-1:0]
`ifdef PWM_RANGE_CHK_EN
    ,
    output logic               range_err
`endif
);
    localparam int CW = $clog2(N);

    state_t             state_d, state_q;
    logic [CW-1:0]      cnt_d, cnt_q;
    logic [COEFF_W-1:0] a_d [N-1:0];
    logic [COEFF_W-1:0] a_q [N-1:0];
    logic [COEFF_W-1:0] b_d [N-1:0];
    logic [COEFF_W-1:0] b_q [N-1:0];
    logic [COEFF_W-1:0] res_d [N-1:0];
    logic [COEFF_W-1:0] res_q [N-1:0];
    logic [COEFF_W-1:0] out_d [N-1:0];
    logic [COEFF_W-1:0] out_q [N-1:0];
    logic               vout_d, vout_q;

    logic               mm_in_vld;
    logic               mm_vld;
    logic [CW-1:0]      mm_idx;
    coeff_t             mm_res;

`ifdef PWM_RANGE_CHK_EN
    logic               range_err_d, range_err_q;
    logic               range_hit;

    // Any incoming operand outside [0, q) flags the vector.
    always_comb begin
        range_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (a_coeffs[i] >= COEFF_W'(Q) || b_coeffs[i] >= COEFF_W'(Q)) begin
                range_hit = 1'b1;
            end
        end
    end
`endif

    assign mm_in_vld = (state_q == RUN);

    mod_mult_q #(
        .IDX_W (CW)
    ) u_mm (
        .clk     (clk),
        .r       (r),
        .in_vld  (mm_in_vld),
        .in_idx  (cnt_q),
        .in_a    (a_q[cnt_q]),
        .in_b    (b_q[cnt_q]),
        .out_vld (mm_vld),
        .out_idx (mm_idx),
        .out_res (mm_res)
    );

    // FSM next state, operand latching, result capture and output bundle load.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        out_d   = out_q;
        vout_d  = 1'b0;
`ifdef PWM_RANGE_CHK_EN
        range_err_d = range_err_q;
`endif
        if (mm_vld) begin
            res_d[mm_idx] = mm_res;
        end
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    a_d     = a_coeffs;
                    b_d     = b_coeffs;
`ifdef PWM_RANGE_CHK_EN
                    range_err_d = range_hit;
`endif
                end
            end
            RUN: begin
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = CW'(cnt_q + 1'b1);
                end
            end
            DRAIN: begin
                // res_d already carries the last lane, which bypasses res_buf.
                if (mm_vld && mm_idx == CW'(N - 1)) begin
                    state_d = IDLE;
                    out_d   = res_d;
                    vout_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, datapath and output registers; reset drops any partial vector.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vout_q  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                a_q[i]   <= '0;
                b_q[i]   <= '0;
                res_q[i] <= '0;
                out_q[i] <= '0;
            end
`ifdef PWM_RANGE_CHK_EN
            range_err_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vout_q  <= vout_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            out_q   <= out_d;
`ifdef PWM_RANGE_CHK_EN
            range_err_q <= range_err_d;
`endif
        end
    end

    assign busy       = (state_q != IDLE);
    assign valid_out  = vout_q;
    assign coeffs_out = out_q;
`ifdef PWM_RANGE_CHK_EN
    assign range_err  = range_err_q;
`endif
endmodule

// File: tb/tb_pointwise_mul_ntt.sv
// Self-checking bench for pointwise_mul_ntt: vector table, random vectors,
// back-to-back, mid-vector reset, output stability and optional range flag.
module tb_pointwise_mul_ntt;
    typedef logic [7:0][11:0] vec12_t;
    typedef struct {
        vec12_t a;
        vec12_t b;
        vec12_t e;
    } rec_t;

    logic        clk;
    logic        r;
    logic [11:0] a_coeffs   [7:0];
    logic [11:0] b_coeffs   [7:0];
    logic        valid_in;
    logic        busy;
    logic        valid_out;
    logic [11:0] coeffs_out [7:0];
`ifdef PWM_RANGE_CHK_EN
    logic        range_err;
`endif

    int checks = 0;
    int errors = 0;

    pointwise_mul_ntt dut (
        .clk        (clk),
        .r          (r),
        .a_coeffs   (a_coeffs),
        .b_coeffs   (b_coeffs),
        .valid_in   (valid_in),
        .busy       (busy),
        .valid_out  (valid_out),
        .coeffs_out (coeffs_out)
`ifdef PWM_RANGE_CHK_EN
        ,
        .range_err  (range_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec12_t model(input vec12_t a, input vec12_t b);
        vec12_t e;
        for (int i = 0; i < 8; i++) begin
            e[i] = 12'((int'(a[i]) * int'(b[i])) % 3329);
        end
        return e;
    endfunction

    function automatic vec12_t got_out();
        vec12_t g;
        for (int i = 0; i < 8; i++) g[i] = coeffs_out[i];
        return g;
    endfunction

    function automatic vec12_t rand_vec();
        vec12_t v;
        for (int i = 0; i < 8; i++) v[i] = 12'($urandom_range(0, 4095));
        return v;
    endfunction

    task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec12_t a, input vec12_t b);
        for (int i = 0; i < 8; i++) begin
            a_coeffs[i] = a[i];
            b_coeffs[i] = b[i];
        end
    endtask

    // Issue one vector, measure latency and busy-high cycles.
    task automatic run_vec(input vec12_t a, input vec12_t b,
                           output int lat, output int busy_cyc);
        @(negedge clk);
        drive(a, b);
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lat      = 0;
        busy_cyc = busy ? 1 : 0;
        while (!valid_out && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cyc++;
        end
    endtask

    rec_t tbl[11];

    initial begin
        int     lat, bc, hits, bad;
        vec12_t va, vb, old;
        vec12_t bb[31];
        vec12_t ab[31];

        // Directed rows first, then random rows with model expectations.
        for (int i = 0; i < 8; i++) begin
            tbl[0].a[i] = 12'd1;    tbl[0].b[i] = 12'(i);    tbl[0].e[i] = 12'(i);
            tbl[1].a[i] = 12'd3328; tbl[1].b[i] = 12'd3328; tbl[1].e[i] = 12'd1;
            tbl[2].a[i] = 12'd1600; tbl[2].b[i] = 12'd2580; tbl[2].e[i] = 12'd40;
        end
        for (int k = 3; k < 11; k++) begin
            tbl[k].a = rand_vec();
            tbl[k].b = rand_vec();
            tbl[k].e = model(tbl[k].a, tbl[k].b);
        end

        r        = 1'b0;
        valid_in = 1'b0;
        drive('0, '0);
        #2;
        chk("reset_busy", 96'(busy), 96'd0);
        chk("reset_valid_out", 96'(valid_out), 96'd0);
        chk("reset_coeffs", 96'(got_out()), 96'd0);
`ifdef PWM_RANGE_CHK_EN
        chk("reset_range_err", 96'(range_err), 96'd0);
`endif
        @(negedge clk);
        r = 1'b1;

        for (int k = 0; k < 11; k++) begin
            run_vec(tbl[k].a, tbl[k].b, lat, bc);
            chk($sformatf("latency[%0d]", k), 96'(lat), 96'd9);
            chk($sformatf("busy_cycles[%0d]", k), 96'(bc), 96'd9);
            chk($sformatf("busy_at_done[%0d]", k), 96'(busy), 96'd0);
            chk($sformatf("coeffs[%0d]", k), 96'(got_out()), 96'(tbl[k].e));
            @(posedge clk);
            #1;
            chk($sformatf("pulse_width[%0d]", k), 96'(valid_out), 96'd0);
        end

        // valid_in held high while operands change every cycle.
        hits = 0;
        bad  = 0;
        for (int c = 0; c < 31; c++) begin
            @(negedge clk);
            ab[c] = rand_vec();
            bb[c] = rand_vec();
            drive(ab[c], bb[c]);
            valid_in = 1'b1;
            @(posedge clk);
            #1;
            if (valid_out) begin
                hits++;
                if (c < 9 || (c % 10) != 9) bad++;
                else chk($sformatf("b2b_coeffs[%0d]", c), 96'(got_out()),
                         96'(model(ab[c-9], bb[c-9])));
            end
        end
        valid_in = 1'b0;
        chk("b2b_pulse_count", 96'(hits), 96'd3);
        chk("b2b_pulse_timing", 96'(bad), 96'd0);
        lat = 0;
        while (busy && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_drain", 96'(busy), 96'd0);

        // Asynchronous reset four edges into a vector.
        @(negedge clk);
        drive(tbl[1].a, tbl[1].b);
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        r = 1'b0;
        #1;
        chk("midrst_busy", 96'(busy), 96'd0);
        chk("midrst_valid_out", 96'(valid_out), 96'd0);
        chk("midrst_coeffs", 96'(got_out()), 96'd0);
        @(negedge clk);
        r    = 1'b1;
        hits = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (valid_out || busy) hits++;
        end
        chk("midrst_no_output", 96'(hits), 96'd0);
        va = rand_vec();
        vb = rand_vec();
        run_vec(va, vb, lat, bc);
        chk("midrst_relaunch_lat", 96'(lat), 96'd9);
        chk("midrst_relaunch_coeffs", 96'(got_out()), 96'(model(va, vb)));

        // Old bundle must hold until the new vector completes.
        old = got_out();
        va  = rand_vec();
        vb  = rand_vec();
        @(negedge clk);
        drive(va, vb);
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        bad = (got_out() !== old) ? 1 : 0;
        for (int c = 1; c < 9; c++) begin
            @(posedge clk);
            #1;
            if (got_out() !== old || valid_out) bad++;
        end
        chk("stable_hold", 96'(bad), 96'd0);
        @(posedge clk);
        #1;
        chk("stable_new_valid", 96'(valid_out), 96'd1);
        chk("stable_new_coeffs", 96'(got_out()), 96'(model(va, vb)));

`ifdef PWM_RANGE_CHK_EN
        for (int i = 0; i < 8; i++) begin
            va[i] = 12'(100 + i);
            vb[i] = 12'd1;
        end
        va[3] = 12'd4095;
        run_vec(va, vb, lat, bc);
        chk("range_err_high", 96'(range_err), 96'd1);
        chk("range_lane3", 96'(coeffs_out[3]), 96'd766);
        va[3] = 12'd3328;
        run_vec(va, vb, lat, bc);
        chk("range_err_low", 96'(range_err), 96'd0);
        chk("range_lane3_ok", 96'(coeffs_out[3]), 96'd3328);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
